mem_wb_skid_reg: RTL and testbench

- Parametrised successor to the fixed MEM/WB pipeline register, feeding the register-file write port.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from writeback stalls cleanly without combinational ready paths.
- Adds synchronous flush, a registered writeback-data mux with zero-register write suppression, and a saturating stall counter.

---
 rtl/mem_wb_skid_reg.sv | 144 ++++++++++++++
 tb/tb_mem_wb_skid_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a two-entry skid buffer and a valid/ready handshake.
// Writeback data is resolved as an entry enters the output stage and is held in a register.
`timescale 1ns/1ps
module mem_wb_skid_reg #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned ZERO_REG    = 31,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_ADDR_W-1:0]  rt_in,
  input  logic                   mem_to_reg_in,
  input  logic                   reg_write_in,
  input  logic [DATA_W-1:0]      alu_result_in,
  input  logic [DATA_W-1:0]      read_data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REG_ADDR_W-1:0]  rt_out,
  output logic                   mem_to_reg_out,
  output logic                   reg_write_out,
  output logic [DATA_W-1:0]      alu_result_out,
  output logic [DATA_W-1:0]      read_data_out,
  output logic [DATA_W-1:0]      wb_data_out,
  output logic                   wb_en_out,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rt;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rd;
  } entry_t;

  entry_t                 in_e;
  entry_t                 main_q, main_d;
  entry_t                 skid_q, skid_d;
  logic                   main_v_q, main_v_d;
  logic                   skid_v_q, skid_v_d;
  logic                   in_ready_q, in_ready_d;
  logic [DATA_W-1:0]      wb_data_q, wb_data_d;
  logic                   wb_en_q, wb_en_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   accept, pop;

  function automatic logic [DATA_W-1:0] wb_sel(input entry_t e);
    return e.mem_to_reg ? e.rd : e.alu;
  endfunction

  always_comb begin
    in_e.rt         = rt_in;
    in_e.mem_to_reg = mem_to_reg_in;
    in_e.reg_write  = reg_write_in;
    in_e.alu        = alu_result_in;
    in_e.rd         = read_data_in;
  end

  assign accept = in_valid & in_ready_q;
  assign pop    = main_v_q & out_ready;

  always_comb begin
    main_d      = main_q;
    main_v_d    = main_v_q;
    skid_d      = skid_q;
    skid_v_d    = skid_v_q;
    wb_data_d   = wb_data_q;
    stall_cnt_d = stall_cnt_q;

    if (main_v_q && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;

    // Flush only clears the valid bits; held data stays visible on the outputs.
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q) begin
      if (accept) begin
        main_d    = in_e;
        wb_data_d = wb_sel(in_e);
        main_v_d  = 1'b1;
      end
    end else if (pop) begin
      if (skid_v_q) begin
        main_d    = skid_q;
        wb_data_d = wb_sel(skid_q);
        if (accept) skid_d   = in_e;
        else        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d    = in_e;
        wb_data_d = wb_sel(in_e);
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = in_e;
      skid_v_d = 1'b1;
    end

    in_ready_d = !skid_v_d;
    wb_en_d    = main_v_d & main_d.reg_write &
                 (main_d.rt != REG_ADDR_W'(ZERO_REG));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      wb_data_q   <= '0;
      wb_en_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      main_q      <= main_d;
      skid_q      <= skid_d;
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      in_ready_q  <= in_ready_d;
      wb_data_q   <= wb_data_d;
      wb_en_q     <= wb_en_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = main_v_q;
  assign rt_out         = main_q.rt;
  assign mem_to_reg_out = main_q.mem_to_reg;
  assign reg_write_out  = main_q.reg_write;
  assign alu_result_out = main_q.alu;
  assign read_data_out  = main_q.rd;
  assign wb_data_out    = wb_data_q;
  assign wb_en_out      = wb_en_q;
  assign occupancy      = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: a FIFO-level reference queue predicts handshake,
// occupancy, head fields, writeback data/enable and the saturating stall counter every cycle.
`timescale 1ns/1ps
module tb_mem_wb_skid_reg;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [4:0]  rt_in, rt_out;
  logic        mem_to_reg_in, reg_write_in, mem_to_reg_out, reg_write_out;
  logic [63:0] alu_result_in, read_data_in, alu_result_out, read_data_out, wb_data_out;
  logic        wb_en_out;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  always #5 clock = ~clock;

  mem_wb_skid_reg #(
    .DATA_W(64), .REG_ADDR_W(5), .ZERO_REG(31), .STALL_CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rt_in(rt_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .alu_result_in(alu_result_in), .read_data_in(read_data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .rt_out(rt_out), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .alu_result_out(alu_result_out), .read_data_out(read_data_out),
    .wb_data_out(wb_data_out), .wb_en_out(wb_en_out),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [4:0]  rt;
    logic        m2r;
    logic        rw;
    logic [63:0] alu;
    logic [63:0] rd;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        disp;
  ent_t        cur_in;
  int unsigned model_cnt;
  bit          started, acc_flag, m_acc;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always_comb cur_in = '{rt: rt_in, m2r: mem_to_reg_in, rw: reg_write_in,
                         alu: alu_result_in, rd: read_data_in};

  // Reference model updates on the edge, then compares DUT outputs 1 ns later.
  always @(posedge clock) begin
    acc_flag = 1'b0;
    if (reset) begin
      exp_q.delete();
      model_cnt = 0;
      disp = '0;
      started = 1'b1;
    end else if (started) begin
      if (exp_q.size() > 0 && !out_ready && model_cnt != 32'hFFFF) model_cnt++;
      if (flush) begin
        exp_q.delete();
      end else begin
        m_acc = in_valid && (exp_q.size() < 2);
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (m_acc) begin
          exp_q.push_back(cur_in);
          acc_flag = 1'b1;
        end
      end
      if (exp_q.size() > 0) disp = exp_q[0];
    end
    #1;
    if (started) begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("stall_cnt", 64'(stall_cnt), 64'(model_cnt));
      chk("rt_out", 64'(rt_out), 64'(disp.rt));
      chk("mem_to_reg_out", 64'(mem_to_reg_out), 64'(disp.m2r));
      chk("reg_write_out", 64'(reg_write_out), 64'(disp.rw));
      chk("alu_result_out", alu_result_out, disp.alu);
      chk("read_data_out", read_data_out, disp.rd);
      chk("wb_data_out", wb_data_out, disp.m2r ? disp.rd : disp.alu);
      chk("wb_en_out", 64'(wb_en_out),
          64'(exp_q.size() > 0 && disp.rw && disp.rt != 5'd31));
    end
  end

  task automatic drive(input ent_t e);
    rt_in = e.rt; mem_to_reg_in = e.m2r; reg_write_in = e.rw;
    alu_result_in = e.alu; read_data_in = e.rd;
  endtask

  task automatic send(input ent_t e);
    in_valid = 1'b1;
    drive(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (acc_flag) break;
    end
    checks++;
    if (!acc_flag) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept for rt=%0d", e.rt);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic ent_t mk(input logic [4:0] rt, input logic m2r, input logic rw,
                              input logic [63:0] alu, input logic [63:0] rd);
    return '{rt: rt, m2r: m2r, rw: rw, alu: alu, rd: rd};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive('0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Streaming: pop and accept in the same cycle.
    send(mk(5'd3, 1'b0, 1'b1, 64'h10, 64'h55));
    send(mk(5'd4, 1'b1, 1'b1, 64'h99, 64'hAB));
    send(mk(5'd5, 1'b0, 1'b1, 64'h1234, 64'h0));
    idle(3);

    // Back-pressure: A to main, B to skid, C held by the source.
    out_ready = 1'b0;
    send(mk(5'd10, 1'b0, 1'b1, 64'hA0, 64'hA1));
    send(mk(5'd11, 1'b1, 1'b1, 64'hB0, 64'hB1));
    in_valid = 1'b1;
    drive(mk(5'd12, 1'b0, 1'b1, 64'hC0, 64'hC1));
    repeat (3) @(negedge clock);
    out_ready = 1'b1;
    send(mk(5'd12, 1'b0, 1'b1, 64'hC0, 64'hC1));
    send(mk(5'd13, 1'b1, 1'b0, 64'hD0, 64'hD1));
    idle(4);

    // Flush at occupancy 2 while E is offered.
    out_ready = 1'b0;
    send(mk(5'd14, 1'b0, 1'b1, 64'h140, 64'h141));
    send(mk(5'd15, 1'b1, 1'b1, 64'h150, 64'h151));
    in_valid = 1'b1;
    drive(mk(5'd16, 1'b0, 1'b1, 64'hE0, 64'hE1));
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    idle(2);

    // Flush at occupancy 1 coincident with an accept of F.
    out_ready = 1'b0;
    send(mk(5'd17, 1'b1, 1'b1, 64'h170, 64'h171));
    in_valid = 1'b1;
    drive(mk(5'd18, 1'b0, 1'b1, 64'hF0, 64'hF1));
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    out_ready = 1'b1;
    send(mk(5'd19, 1'b1, 1'b1, 64'h190, 64'h191));
    idle(2);

    // Zero-register and no-write entries flow but do not enable writeback.
    send(mk(5'd31, 1'b0, 1'b1, 64'h310, 64'h311));
    send(mk(5'd7, 1'b1, 1'b0, 64'h70, 64'h71));
    send(mk(5'd30, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0));
    idle(2);

    // Reset while full and stalled.
    do_reset();
    out_ready = 1'b0;
    send(mk(5'd20, 1'b0, 1'b1, 64'h200, 64'h201));
    send(mk(5'd21, 1'b1, 1'b1, 64'h210, 64'h211));
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (model_cnt == 5) break;
      @(negedge clock);
    end
    chk("stall_before_reset", 64'(stall_cnt), 64'h5);
    do_reset();
    @(negedge clock);

    // Saturation of the stall counter.
    send(mk(5'd22, 1'b0, 1'b1, 64'h220, 64'h221));
    idle(65536 + 3);
    chk("stall_saturated", 64'(stall_cnt), 64'hFFFF);
    out_ready = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
